uart_frame_rx: RTL and testbench



---
 rtl/uart_pkg.sv | 17 +
 rtl/uart_sync2.sv | 20 ++
 rtl/uart_frame_rx.sv | 168 ++++++++++++++++
 tb/tb_uart_frame_rx.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared serial-link package: receiver FSM states and default link constants.
// The same defaults are used by the transmitter so both ends agree.
package uart_pkg;

   localparam int UART_PACKET_SIZE = 16;
   localparam int UART_CYCLE_DIV   = 100;
   localparam int UART_PROP_DELAY  = 2;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      ALIGN    = 3'd1,
      SHIFT    = 3'd2,
      COMMIT   = 3'd3,
      WAIT_LOW = 3'd4
   } rx_state_t;

endpackage

// File: rtl/uart_sync2.sv
// Single-bit two-flop synchroniser for asynchronous pin inputs.
// Resets to 0 so an idle line reads low after reset.
module uart_sync2 (
   input  logic clk,
   input  logic rst_n,
   input  logic d_i,
   output logic q_o
);

   logic [1:0] sync_q;

   // shift the input through two flops
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sync_q <= '0;
      else        sync_q <= {sync_q[0], d_i};
   end

   assign q_o = sync_q[1];

endmodule

// File: rtl/uart_frame_rx.sv
// Frame receiver: bitstream + "sending" qualifier in, word on valid/ready out.
// Define UART_RX_SYNC_EN to pass both inputs through two-flop synchronisers.
module uart_frame_rx
   import uart_pkg::*;
#(
   parameter int PACKET_SIZE = UART_PACKET_SIZE,
   parameter int CYCLE_DIV   = UART_CYCLE_DIV,
   parameter int PROP_DELAY  = UART_PROP_DELAY
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   bs_in,
   input  logic                   rec_sig,
   output logic [PACKET_SIZE-1:0] data,
   output logic                   data_valid,
   input  logic                   data_ready,
   output logic                   frame_err,
   output logic                   overrun,
   output logic                   busy
);

   localparam int CNT_W = $clog2(PROP_DELAY*CYCLE_DIV + CYCLE_DIV);
   localparam int IDX_W = $clog2(PACKET_SIZE + 1);

   localparam logic [CNT_W-1:0] ALIGN_LOAD =
      CNT_W'(PROP_DELAY*CYCLE_DIV + CYCLE_DIV/2 - 1);
   localparam logic [CNT_W-1:0] BIT_LOAD = CNT_W'(CYCLE_DIV - 1);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PACKET_SIZE - 1);

   logic bs_s;
   logic sig_s;

`ifdef UART_RX_SYNC_EN
   uart_sync2 u_sync_bs (
      .clk   (clk),
      .rst_n (rst_n),
      .d_i   (bs_in),
      .q_o   (bs_s)
   );

   uart_sync2 u_sync_sig (
      .clk   (clk),
      .rst_n (rst_n),
      .d_i   (rec_sig),
      .q_o   (sig_s)
   );
`else
   assign bs_s  = bs_in;
   assign sig_s = rec_sig;
`endif

   rx_state_t              state_q, state_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [IDX_W-1:0]       idx_q, idx_d;
   logic [PACKET_SIZE-1:0] shift_q, shift_d;
   logic [PACKET_SIZE-1:0] data_q, data_d;
   logic                   valid_q, valid_d;
   logic                   ferr_q, ferr_d;
   logic                   ovr_q, ovr_d;
   logic                   sig_q;
   logic                   sig_rise;

   assign sig_rise = sig_s & ~sig_q;

   // next-state logic: frame alignment, bit sampling, commit and handshake
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      shift_d = shift_q;
      data_d  = data_q;
      valid_d = valid_q;
      ferr_d  = 1'b0;
      ovr_d   = 1'b0;

      if (valid_q && data_ready) valid_d = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (sig_rise) begin
               state_d = ALIGN;
               cnt_d   = ALIGN_LOAD;
            end
         end
         ALIGN: begin
            if (!sig_s) begin
               ferr_d  = 1'b1;
               state_d = IDLE;
               cnt_d   = '0;
            end else if (cnt_q == '0) begin
               shift_d[0] = bs_s;
               idx_d      = IDX_W'(1);
               cnt_d      = BIT_LOAD;
               state_d    = (PACKET_SIZE == 1) ? COMMIT : SHIFT;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         SHIFT: begin
            if (!sig_s) begin
               ferr_d  = 1'b1;
               state_d = IDLE;
               cnt_d   = '0;
               idx_d   = '0;
            end else if (cnt_q == '0) begin
               for (int i = 0; i < PACKET_SIZE; i++) begin
                  if (idx_q == IDX_W'(i)) shift_d[i] = bs_s;
               end
               cnt_d = BIT_LOAD;
               if (idx_q == LAST_IDX) begin
                  idx_d   = '0;
                  state_d = COMMIT;
               end else begin
                  idx_d = idx_q + IDX_W'(1);
               end
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         COMMIT: begin
            data_d  = shift_q;
            valid_d = 1'b1;
            ovr_d   = valid_q && !data_ready;
            cnt_d   = '0;
            idx_d   = '0;
            state_d = WAIT_LOW;
         end
         WAIT_LOW: begin
            if (!sig_s) state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // state and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         shift_q <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         ferr_q  <= 1'b0;
         ovr_q   <= 1'b0;
         sig_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         shift_q <= shift_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         ferr_q  <= ferr_d;
         ovr_q   <= ovr_d;
         sig_q   <= sig_s;
      end
   end

   assign data       = data_q;
   assign data_valid = valid_q;
   assign frame_err  = ferr_q;
   assign overrun    = ovr_q;
   assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_uart_frame_rx.sv
// Bench for uart_frame_rx: frames driven bit-by-bit from a word,
// expected words/errors queued at frame start, popped by a monitor.
`timescale 1ns/1ps
module tb_uart_frame_rx;

   localparam int PS  = 8;
   localparam int DIV = 8;
   localparam int PD  = 2;
`ifdef UART_RX_SYNC_EN
   localparam int SYNC_LAT = 2;
`else
   localparam int SYNC_LAT = 0;
`endif
   // edge of last mid-bit sample after the rec_sig drive edge, plus commit
   localparam int LAT = PD*DIV + (PS-1)*DIV + DIV/2 + 1 + 1 + SYNC_LAT;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          bs_in = 1'b0;
   logic          rec_sig = 1'b0;
   logic          data_ready = 1'b0;
   logic [PS-1:0] data;
   logic          data_valid;
   logic          frame_err;
   logic          overrun;
   logic          busy;

   int tests = 0;
   int fails = 0;
   int cyc = 0;
   int rdy_mode = 0;
   int ovr_seen = 0;
   int ferr_seen = 0;
   int start_cyc = 0;
   int rise_cyc = 0;
   logic dv_prev = 1'b0;

   logic [PS-1:0] word_q[$];
   int            err_q[$];

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   uart_frame_rx #(
      .PACKET_SIZE (PS),
      .CYCLE_DIV   (DIV),
      .PROP_DELAY  (PD)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .bs_in      (bs_in),
      .rec_sig    (rec_sig),
      .data       (data),
      .data_valid (data_valid),
      .data_ready (data_ready),
      .frame_err  (frame_err),
      .overrun    (overrun),
      .busy       (busy)
   );

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // consumer: ready changes just after the active edge
   initial begin
      forever begin
         @(posedge clk);
         #1;
         case (rdy_mode)
            0:       data_ready = 1'b0;
            1:       data_ready = 1'b1;
            default: data_ready = ($urandom_range(0, 3) == 0);
         endcase
      end
   end

   // monitor: pops expectations on every DUT event
   initial begin
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            dv_prev = 1'b0;
         end else begin
            if (data_valid && !dv_prev) rise_cyc = cyc;
            dv_prev = data_valid;
            if (frame_err) begin
               ferr_seen++;
               check("ferr_expected", 32'(err_q.size() != 0), 1);
               if (err_q.size() != 0) void'(err_q.pop_front());
            end
            if (overrun) begin
               ovr_seen++;
               check("ovr_pending", 32'(word_q.size() >= 2), 1);
               if (word_q.size() >= 2) begin
                  void'(word_q.pop_front());
                  check("ovr_data", 32'(data), 32'(word_q[0]));
               end
            end
            if (data_valid && data_ready) begin
               check("hs_pending", 32'(word_q.size() != 0), 1);
               if (word_q.size() != 0)
                  check("hs_data", 32'(data), 32'(word_q.pop_front()));
            end
         end
      end
   end

   // abort_bit < 0: full frame; else drop rec_sig at start of that bit
   task automatic send_frame(input logic [PS-1:0] w, input int abort_bit,
                             input int hold);
      bit aborted = 1'b0;
      @(posedge clk);
      #1;
      if (abort_bit < 0) word_q.push_back(w);
      else               err_q.push_back(1);
      start_cyc = cyc;
      rec_sig = 1'b1;
      repeat (PD*DIV) @(posedge clk);
      for (int b = 0; b < PS; b++) begin
         #1;
         if (b == abort_bit) begin
            rec_sig = 1'b0;
            aborted = 1'b1;
            break;
         end
         bs_in = w[b];
         repeat (DIV) @(posedge clk);
      end
      if (!aborted) begin
         #1;
         repeat (hold) @(posedge clk);
         rec_sig = 1'b0;
      end
      repeat (6) @(posedge clk);
   endtask

   task automatic drain();
      int n = 0;
      rdy_mode = 1;
      while ((word_q.size() != 0 || err_q.size() != 0 || data_valid)
             && n < 500) begin
         @(posedge clk);
         n++;
      end
      @(negedge clk);
      check("drain", 32'(word_q.size() == 0 && err_q.size() == 0
                         && !data_valid), 1);
   endtask

   initial begin
      int o;
      int f;
      logic [PS-1:0] w;
      int ab;

      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_data", 32'(data), 0);
      check("rst_valid", 32'(data_valid), 0);
      check("rst_ferr", 32'(frame_err), 0);
      check("rst_ovr", 32'(overrun), 0);
      check("rst_busy", 32'(busy), 0);
      rst_n = 1'b1;

      rdy_mode = 0;
      send_frame(8'h81, -1, 0);
      check("latency", 32'(rise_cyc - start_cyc), 32'(LAT));
      repeat (20) @(posedge clk);
      #1;
      check("hold_valid", 32'(data_valid), 1);
      check("hold_data", 32'(data), 32'h81);
      check("idle_busy", 32'(busy), 0);
      drain();

      rdy_mode = 0;
      o = ovr_seen;
      send_frame(8'h01, -1, 0);
      send_frame(8'hFF, -1, 0);
      #1;
      check("ovr_count", 32'(ovr_seen - o), 1);
      check("ovr_final_data", 32'(data), 32'hFF);
      check("ovr_final_valid", 32'(data_valid), 1);
      drain();

      f = ferr_seen;
      send_frame(8'h5A, 5, 0);
      #1;
      check("abort_count", 32'(ferr_seen - f), 1);
      check("abort_keep_data", 32'(data), 32'hFF);
      check("abort_valid", 32'(data_valid), 0);
      send_frame(8'h34, -1, 0);
      drain();

      send_frame(8'hC3, -1, 50*DIV);
      drain();

      rdy_mode = 2;
      for (int i = 0; i < 40; i++) begin
         w = 8'($urandom);
         ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, PS-1)) : -1;
         send_frame(w, ab, int'($urandom_range(0, 3)));
      end
      drain();

      send_frame(8'hA5, -1, 0);
      drain();
      @(posedge clk);
      #1;
      rec_sig = 1'b1;
      repeat (PD*DIV + 3*DIV) @(posedge clk);
      #1;
      check("busy_mid", 32'(busy), 1);
      #2;
      rst_n = 1'b0;
      #1;
      check("mid_rst_data", 32'(data), 0);
      check("mid_rst_valid", 32'(data_valid), 0);
      check("mid_rst_busy", 32'(busy), 0);
      check("mid_rst_ferr", 32'(frame_err), 0);
      rec_sig = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (4) @(posedge clk);
      send_frame(8'hEF, -1, 0);
      drain();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
